// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared encodings for the pipeline hazard controller:
//                write-back source codes, forwarding selects and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Write-back source codes carried with the instruction in EX
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // ALU operand forwarding selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Multi-cycle EX tracking states
  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } hz_state_e;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_unit
//  Description : Combinational forwarding compare for one EX source operand.
//                MEM result has priority over WB result; x0 never forwards.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_E,
  input  logic [4:0] rd_M,
  input  logic       we_reg_M,
  input  logic [4:0] rd_W,
  input  logic       we_reg_W,
  output logic [1:0] fwd_sel
);

  // Pick the youngest in-flight producer of rs_E
  always_comb begin
    fwd_sel = FWD_RF;
    if (we_reg_M && (rd_M != 5'd0) && (rd_M == rs_E)) begin
      fwd_sel = FWD_MEM;
    end else if (we_reg_W && (rd_W != 5'd0) && (rd_W == rs_E)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule : hazard_fwd_unit
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Stall/flush sequencing and EX forwarding selects for the
//                5-stage core. Priority: memory wait > multi-cycle EX op >
//                branch redirect > load-use.
//                Optional macro HAZARD_PERF_CNT_EN adds saturating
//                stall_cycles / flush_events counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = $clog2(MC_LAT + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic [4:0]  rs1_E,
  input  logic [4:0]  rs2_E,
  input  logic [4:0]  rd_E,
  input  logic [1:0]  wb_ctrl_E,
  input  logic [4:0]  rd_M,
  input  logic        we_reg_M,
  input  logic [4:0]  rd_W,
  input  logic        we_reg_W,
  input  logic        branch_taken_E,
  input  logic        mc_start_E,
  input  logic        mem_req_M,
  input  logic        mem_ready_M,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_E,
  output logic        stall_M,
  output logic        flush_D,
  output logic        flush_E,
  output logic        flush_M,
  output logic        flush_W,
  output logic [1:0]  fwd_a_E,
  output logic [1:0]  fwd_b_E,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
`endif
  output logic        mc_busy
);

  // MC_LAT of 1 means the op never holds EX beyond its own cycle
  localparam bit              c_mc_en       = (MC_LAT > 1);
  localparam int              c_load_int    = (MC_LAT > 1) ? (MC_LAT - 2) : 0;
  localparam logic [CNT_W-1:0] c_cnt_load   = c_load_int[CNT_W-1:0];

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       w_mem_stall;
  logic       w_mc_stall;
  logic       w_load_use;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_mem_stall = mem_req_M & ~mem_ready_M;

  // The first cycle of an op (RUN + start) and every busy cycle with cnt!=0 stall
  assign w_mc_stall = c_mc_en &&
                      (((state_q == RUN) && mc_start_E) ||
                       ((state_q == MC_BUSY) && (cnt_q != '0)));

  assign w_load_use = (wb_ctrl_E == WB_MEM) && (rd_E != 5'd0) &&
                      ((rd_E == rs1_D) || (rd_E == rs2_D));

  hazard_fwd_unit u_fwd_a (
    .rs_E     (rs1_E),
    .rd_M     (rd_M),
    .we_reg_M (we_reg_M),
    .rd_W     (rd_W),
    .we_reg_W (we_reg_W),
    .fwd_sel  (w_fwd_a)
  );

  hazard_fwd_unit u_fwd_b (
    .rs_E     (rs2_E),
    .rd_M     (rd_M),
    .we_reg_M (we_reg_M),
    .rd_W     (rd_W),
    .we_reg_W (we_reg_W),
    .fwd_sel  (w_fwd_b)
  );

  // State register: reset aborts any op in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: everything freezes while memory holds the pipe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!w_mem_stall) begin
      case (state_q)
        RUN: begin
          if (mc_start_E && c_mc_en) begin
            state_d = MC_BUSY;
            cnt_d   = c_cnt_load;
          end
        end
        MC_BUSY: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode in priority order; all quiet while reset is asserted
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_M = 1'b0;
    flush_W = 1'b0;
    fwd_a_E = FWD_RF;
    fwd_b_E = FWD_RF;
    mc_busy = 1'b0;
    if (rst_n) begin
      fwd_a_E = w_fwd_a;
      fwd_b_E = w_fwd_b;
      mc_busy = (state_q == MC_BUSY);
      if (w_mem_stall) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
        flush_W = 1'b1;
      end else if (w_mc_stall) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        flush_M = 1'b1;
      end else if (branch_taken_E) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (w_load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  // Saturating event counters
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (stall_F && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if ((flush_D || flush_E) && (flush_events_q != 32'hFFFF_FFFF)) begin
      flush_events_d = flush_events_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed scoreboard bench for hazard_ctrl (MC_LAT = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic [1:0] wb_ctrl_E;
  logic       we_reg_M, we_reg_W, branch_taken_E, mc_start_E, mem_req_M, mem_ready_M;
  logic       stall_F, stall_D, stall_E, stall_M;
  logic       flush_D, flush_E, flush_M, flush_W;
  logic [1:0] fwd_a_E, fwd_b_E;
  logic       mc_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  hazard_ctrl #(.MC_LAT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_D          (rs1_D),
    .rs2_D          (rs2_D),
    .rs1_E          (rs1_E),
    .rs2_E          (rs2_E),
    .rd_E           (rd_E),
    .wb_ctrl_E      (wb_ctrl_E),
    .rd_M           (rd_M),
    .we_reg_M       (we_reg_M),
    .rd_W           (rd_W),
    .we_reg_W       (we_reg_W),
    .branch_taken_E (branch_taken_E),
    .mc_start_E     (mc_start_E),
    .mem_req_M      (mem_req_M),
    .mem_ready_M    (mem_ready_M),
    .stall_F        (stall_F),
    .stall_D        (stall_D),
    .stall_E        (stall_E),
    .stall_M        (stall_M),
    .flush_D        (flush_D),
    .flush_E        (flush_E),
    .flush_M        (flush_M),
    .flush_W        (flush_W),
    .fwd_a_E        (fwd_a_E),
    .fwd_b_E        (fwd_b_E),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events),
`endif
    .mc_busy        (mc_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: {sF,sD,sE,sM, fD,fE,fM,fW, fwd_a[1:0], fwd_b[1:0], busy}
  logic [12:0] exp_q[$];
  string       name_q[$];
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [12:0] mk(input logic sf, input logic sd, input logic se,
                                     input logic sm, input logic fd, input logic fe,
                                     input logic fm, input logic fw, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic busy);
    return {sf, sd, se, sm, fd, fe, fm, fw, fa, fb, busy};
  endfunction

  task automatic expect_out(input string nm, input logic [12:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle();
    rs1_D = 5'd0; rs2_D = 5'd0; rs1_E = 5'd0; rs2_E = 5'd0;
    rd_E = 5'd0; rd_M = 5'd0; rd_W = 5'd0; wb_ctrl_E = 2'b00;
    we_reg_M = 1'b0; we_reg_W = 1'b0; branch_taken_E = 1'b0;
    mc_start_E = 1'b0; mem_req_M = 1'b0; mem_ready_M = 1'b0;
  endtask

  // Advance to just after the next rising edge, where inputs are driven
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each cycle's outputs away from the active edge
  always @(negedge clk) begin
    logic [12:0] got;
    logic [12:0] e;
    string       nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      got = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W,
             fwd_a_E, fwd_b_E, mc_busy};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s got=%b expected=%b", nm, got, e);
      end
    end
  end

  localparam logic [12:0] E_ZERO = 13'b0;
  localparam logic [12:0] E_LU   = 13'b1100_0100_0000_0;
  localparam logic [12:0] E_BR   = 13'b0000_1100_0000_0;
  localparam logic [12:0] E_MC0  = 13'b1110_0010_0000_0;
  localparam logic [12:0] E_MC1  = 13'b1110_0010_0000_1;
  localparam logic [12:0] E_MEM1 = 13'b1111_0001_0000_1;
  localparam logic [12:0] E_BUSY = 13'b0000_0000_0000_1;

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    // Reset holds every output quiet even with all hazards asserted
    step();
    rst_n = 1'b0; mc_start_E = 1'b1; mem_req_M = 1'b1; branch_taken_E = 1'b1;
    rd_M = 5'd7; we_reg_M = 1'b1; rs1_E = 5'd7;
    expect_out("reset_quiet", E_ZERO);

    step(); idle(); rst_n = 1'b1;
    expect_out("idle", E_ZERO);

    // Load-use on rs1, then the load has moved to MEM
    step(); rd_E = 5'd5; wb_ctrl_E = 2'b01; rs1_D = 5'd5;
    expect_out("load_use_rs1", E_LU);
    step(); idle(); rd_M = 5'd5; we_reg_M = 1'b1; rs1_D = 5'd5;
    expect_out("load_use_done", E_ZERO);

    // Load-use on rs2; x0 load and ALU producer never stall
    step(); idle(); rd_E = 5'd9; wb_ctrl_E = 2'b01; rs2_D = 5'd9;
    expect_out("load_use_rs2", E_LU);
    step(); idle(); rd_E = 5'd0; wb_ctrl_E = 2'b01; rs1_D = 5'd0;
    expect_out("load_x0", E_ZERO);
    step(); idle(); rd_E = 5'd5; wb_ctrl_E = 2'b00; rs1_D = 5'd5;
    expect_out("alu_no_stall", E_ZERO);

    // Branch overrides load-use
    step(); idle(); rd_E = 5'd5; wb_ctrl_E = 2'b01; rs1_D = 5'd5; branch_taken_E = 1'b1;
    expect_out("branch_over_lu", E_BR);

    // Forwarding priority and x0 suppression
    step(); idle(); rd_M = 5'd7; rd_W = 5'd7; we_reg_M = 1'b1; we_reg_W = 1'b1;
    rs1_E = 5'd7; rs2_E = 5'd7;
    expect_out("fwd_mem_prio", mk(0,0,0,0,0,0,0,0,2'b10,2'b10,0));
    step(); rd_M = 5'd0; rs2_E = 5'd0;
    expect_out("fwd_wb_x0", mk(0,0,0,0,0,0,0,0,2'b01,2'b00,0));
    step(); rd_M = 5'd7; we_reg_M = 1'b0; rs2_E = 5'd7;
    expect_out("fwd_we_off", mk(0,0,0,0,0,0,0,0,2'b01,2'b01,0));

    // Multi-cycle op, start held across the whole op (no retrigger)
    step(); idle(); mc_start_E = 1'b1;
    expect_out("mc_c1", E_MC0);
    step(); rs1_E = 5'd3; rd_M = 5'd3; we_reg_M = 1'b1;
    expect_out("mc_c2_fwd", mk(1,1,1,0,0,0,1,0,2'b10,2'b00,1));
    step(); rs1_E = 5'd0; rd_M = 5'd0; we_reg_M = 1'b0;
    expect_out("mc_c3", E_MC1);
    step();
    expect_out("mc_c4_release", E_BUSY);
    step(); idle();
    expect_out("mc_after", E_ZERO);

    // Memory wait at cnt=1 extends the op to 5 stall cycles
    step(); mc_start_E = 1'b1;
    expect_out("mw_c1", E_MC0);
    step(); mc_start_E = 1'b0;
    expect_out("mw_c2", E_MC1);
    step(); mem_req_M = 1'b1; mem_ready_M = 1'b0; branch_taken_E = 1'b1;
    rd_E = 5'd4; wb_ctrl_E = 2'b01; rs1_D = 5'd4;
    expect_out("mw_memwait1", E_MEM1);
    step(); branch_taken_E = 1'b0;
    expect_out("mw_memwait2", E_MEM1);
    step(); idle(); mem_req_M = 1'b1; mem_ready_M = 1'b1;
    expect_out("mw_resume", E_MC1);
    step(); idle();
    expect_out("mw_release", E_BUSY);
    step();
    expect_out("mw_after", E_ZERO);

    // Reset while busy with cnt=2 aborts the op
    step(); mc_start_E = 1'b1;
    expect_out("rb_c1", E_MC0);
    step(); mc_start_E = 1'b0; rst_n = 1'b0;
    expect_out("rb_in_reset", E_ZERO);
    step(); rst_n = 1'b1;
    expect_out("rb_after_reset", E_ZERO);
    step(); mc_start_E = 1'b1;
    expect_out("rb_restart1", E_MC0);
    step(); mc_start_E = 1'b0;
    expect_out("rb_restart2", E_MC1);
    step();
    expect_out("rb_restart3", E_MC1);
    step();
    expect_out("rb_restart_release", E_BUSY);
    step();
    expect_out("rb_idle", E_ZERO);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hazard_ctrl
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage core.
- Generates the stall/flush enables that sequence the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the EX-stage forwarding selects.
- Handles three hazard sources:
  - load-use hazards;
  - taken-branch redirects;
  - multi-cycle EX operations, tracked with an internal FSM and down-counter.
- Also freezes the whole pipe while a data-memory access waits on its handshake.

Parameters:
- MC_LAT, 4: cycles a multi-cycle op occupies EX. Legal range 1..16; 1 means no stall.
- CNT_W, $clog2(MC_LAT+1): width of the latency counter (derived).

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: synchronous active-low reset.
- rs1_D, input, 5: source register 1 of the instruction in ID.
- rs2_D, input, 5: source register 2 of the instruction in ID.
- rs1_E, input, 5: source register 1 in EX.
- rs2_E, input, 5: source register 2 in EX.
- rd_E, input, 5: destination register in EX.
- wb_ctrl_E, input, 2: write-back source in EX. WB_MEM=2'b01 marks a load.
- rd_M, input, 5: destination register in MEM.
- we_reg_M, input, 1: register write enable in MEM.
- rd_W, input, 5: destination register in WB.
- we_reg_W, input, 1: register write enable in WB.
- branch_taken_E, input, 1: branch/jump in EX resolved taken (redirect).
- mc_start_E, input, 1: instruction in EX is a multi-cycle op.
- mem_req_M, input, 1: data-memory access active in MEM.
- mem_ready_M, input, 1: data-memory access completes this cycle.
- stall_F, output, 1: hold the PC.
- stall_D, output, 1: hold IF/ID.
- stall_E, output, 1: hold ID/EX.
- stall_M, output, 1: hold EX/MEM.
- flush_D, output, 1: clear IF/ID.
- flush_E, output, 1: clear ID/EX.
- flush_M, output, 1: clear EX/MEM (bubble).
- flush_W, output, 1: clear MEM/WB (bubble).
- fwd_a_E, output, 2: ALU operand A select. 00 = register file, 10 = MEM result, 01 = WB result.
- fwd_b_E, output, 2: ALU operand B select, same encoding.
- mc_busy, output, 1: FSM in MC_BUSY.

Behaviour:
- Reset: clk with rst_n=0 sets state=RUN and cnt=0. While rst_n=0, all stall_*/flush_* outputs are 0, fwd_* = 00 and mc_busy=0.
- Reset mid-MC_BUSY aborts the op: RUN on the next edge, with no stall after reset.
- All stall/flush/fwd outputs are combinational from inputs plus registered state. State and cnt update at the rising edge only.
- mem_stall = mem_req_M & ~mem_ready_M. This is the highest priority.
  - Outputs: stall_F/D/E/M=1, flush_W=1, flush_D/E/M=0.
  - FSM state and cnt hold.
  - branch_taken_E and load-use are ignored, because nothing advances.
- FSM states:
  - RUN, with mc_start_E=1, MC_LAT>1 and no mem_stall: assert stall_F/D/E=1 and flush_M=1. Next state is MC_BUSY with cnt=MC_LAT-2.
  - MC_BUSY, cnt!=0: same outputs; cnt decrements by 1 per unstalled cycle.
  - MC_BUSY, cnt==0: no MC stall, the op leaves EX, next state is RUN. mc_start_E is ignored in this cycle, so there is no retrigger.
  - Net effect: an op occupies EX for exactly MC_LAT cycles, giving MC_LAT-1 stall cycles.
- Branch redirect is honoured only when EX advances (no mem_stall, no MC stall).
  - branch_taken_E=1 gives flush_D=1 and flush_E=1 in the same cycle.
  - This overrides load-use: stall_F/stall_D stay 0 so the redirect PC loads.
- Load-use is evaluated only when EX advances and no branch redirect occurs.
  - Condition: wb_ctrl_E==WB_MEM, rd_E!=0, and rd_E==rs1_D or rd_E==rs2_D.
  - Response: stall_F=1, stall_D=1, flush_E=1 for exactly one cycle.
- Forwarding, operand A (operand B is identical using rs2_E):
  - fwd_a_E=10 if we_reg_M, rd_M!=0 and rd_M==rs1_E.
  - else fwd_a_E=01 if we_reg_W, rd_W!=0 and rd_W==rs1_E.
  - else 00.
  - MEM has priority over WB. x0 is never forwarded.
  - Forwarding stays valid during stalls.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds outputs stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles increments every cycle stall_F=1.
  - flush_events increments every cycle flush_D or flush_E is 1.
  - Both are cleared by rst_n and saturate at 32'hFFFF_FFFF.
- When undefined, the outputs and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - WB_* write-back codes (WB_ALU=00, WB_MEM=01, WB_PC4=10);
  - FWD_RF/FWD_WB/FWD_MEM encodings;
  - the state enum {RUN, MC_BUSY}.
- One sub-module: hazard_fwd_unit, the purely combinational forwarding compare, instantiated once per operand.

Test Plan:
- Load-use: rd_E=5, wb_ctrl_E=01, rs1_D=5 -> one cycle of stall_F=stall_D=flush_E=1; next cycle (load moved to M) all stalls 0.
- MC op: MC_LAT=4, mc_start_E=1 held -> stall_F/D/E=1 and flush_M=1 for exactly 3 cycles, mc_busy=1 for 2 of them, 4th cycle no stall.
- Mem wait during MC_BUSY: mem_req_M=1, mem_ready_M=0 for 2 cycles at cnt=1 -> all stall_*=1, flush_W=1, cnt frozen; total MC stall becomes 5 cycles.
- Branch plus load-use in the same cycle -> flush_D=flush_E=1, stall_F=0.
- Forwarding: rd_M=rd_W=7, both we=1, rs1_E=7 -> fwd_a_E=10. With rd_M=0 -> fwd_a_E=01. With rs2_E=0 -> fwd_b_E=00.
- rst_n=0 for one edge during MC_BUSY cnt=2 -> RUN, all outputs 0; the next mc_start_E restarts the full MC_LAT-1 stall.
